// File: rtl/id_decode_cmp_if.sv
// Decode-stage bus: instruction and forwarded operands in, decode/compare
// results and the D->E control register out.
interface id_decode_cmp_if;
  logic [31:0] instr;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        stall;
  logic [15:0] ibus;
  logic        ext_op;
  logic [1:0]  reg_dst;
  logic        is_branch;
  logic        imm_jump;
  logic        reg_jump;
  logic        cmp_true;
  logic        branch_jump;
  logic [15:0] e_ibus;
  logic [4:0]  e_wra;
  logic [31:0] e_ext;

  modport slave (
    input  instr, rd1, rd2, stall,
    output ibus, ext_op, reg_dst, is_branch, imm_jump, reg_jump,
           cmp_true, branch_jump, e_ibus, e_wra, e_ext
  );

  modport master (
    output instr, rd1, rd2, stall,
    input  ibus, ext_op, reg_dst, is_branch, imm_jump, reg_jump,
           cmp_true, branch_jump, e_ibus, e_wra, e_ext
  );
endinterface

// File: rtl/id_decode_cmp.sv
// id_decode_cmp: MIPS-lite decode stage. Decodes the D-stage instruction into
// a one-hot instruction bus plus control, evaluates the branch condition on
// the forwarded operands, and holds the D->E control register (stall loads a
// bubble). Reset is asynchronous and active-low on port 'reset'.
// Optional feature macro: EXT_BRANCH_EN adds bne/blez/bgtz/bltz/bgez at
// ibus[15:11]; when undefined those encodings decode as unknown and
// ibus[15:11] stays 0.
module id_decode_cmp #(
  parameter logic [4:0] RA_ADDR = 5'd31
) (
  input logic            clk,
  input logic            reset,
  id_decode_cmp_if.slave dbus
);

  localparam int IDX_NOP  = 0;
  localparam int IDX_ADDU = 1;
  localparam int IDX_SUBU = 2;
  localparam int IDX_ORI  = 3;
  localparam int IDX_LW   = 4;
  localparam int IDX_SW   = 5;
  localparam int IDX_BEQ  = 6;
  localparam int IDX_LUI  = 7;
  localparam int IDX_JAL  = 8;
  localparam int IDX_JR   = 9;
  localparam int IDX_J    = 10;
`ifdef EXT_BRANCH_EN
  localparam int IDX_BNE  = 11;
  localparam int IDX_BLEZ = 12;
  localparam int IDX_BGTZ = 13;
  localparam int IDX_BLTZ = 14;
  localparam int IDX_BGEZ = 15;
`endif

  logic [15:0] ibus_c;
  logic        ext_c;
  logic [1:0]  reg_dst_c;
  logic        branch_c;
  logic        imm_jump_c;
  logic        reg_jump_c;
  logic        cmp_c;
  logic [4:0]  wra_c;
  logic [31:0] ext_val_c;

  logic [15:0] e_ibus_q;
  logic [4:0]  e_wra_q;
  logic [31:0] e_ext_q;

  // Decode opcode/funct into the one-hot bus and control; unknown stays all-zero
  always_comb begin
    ibus_c     = '0;
    ext_c      = 1'b0;
    reg_dst_c  = 2'b00;
    branch_c   = 1'b0;
    imm_jump_c = 1'b0;
    reg_jump_c = 1'b0;
    cmp_c      = 1'b0;
    if (dbus.instr == 32'h0000_0000) begin
      ibus_c[IDX_NOP] = 1'b1;
    end else begin
      case (dbus.instr[31:26])
        6'h00: begin
          case (dbus.instr[5:0])
            6'h21: begin
              ibus_c[IDX_ADDU] = 1'b1;
              reg_dst_c        = 2'b10;
            end
            6'h23: begin
              ibus_c[IDX_SUBU] = 1'b1;
              reg_dst_c        = 2'b10;
            end
            6'h08: begin
              ibus_c[IDX_JR] = 1'b1;
              reg_jump_c     = 1'b1;
            end
            default: ;
          endcase
        end
        6'h0D: begin
          ibus_c[IDX_ORI] = 1'b1;
          reg_dst_c       = 2'b01;
        end
        6'h23: begin
          ibus_c[IDX_LW] = 1'b1;
          ext_c          = 1'b1;
          reg_dst_c      = 2'b01;
        end
        6'h2B: begin
          ibus_c[IDX_SW] = 1'b1;
          ext_c          = 1'b1;
        end
        6'h04: begin
          ibus_c[IDX_BEQ] = 1'b1;
          ext_c           = 1'b1;
          branch_c        = 1'b1;
          cmp_c           = (dbus.rd1 == dbus.rd2);
        end
        6'h0F: begin
          ibus_c[IDX_LUI] = 1'b1;
          reg_dst_c       = 2'b01;
        end
        6'h03: begin
          ibus_c[IDX_JAL] = 1'b1;
          imm_jump_c      = 1'b1;
          reg_dst_c       = 2'b11;
        end
        6'h02: begin
          ibus_c[IDX_J] = 1'b1;
          imm_jump_c    = 1'b1;
        end
`ifdef EXT_BRANCH_EN
        6'h05: begin
          ibus_c[IDX_BNE] = 1'b1;
          ext_c           = 1'b1;
          branch_c        = 1'b1;
          cmp_c           = (dbus.rd1 != dbus.rd2);
        end
        6'h06: begin
          ibus_c[IDX_BLEZ] = 1'b1;
          ext_c            = 1'b1;
          branch_c         = 1'b1;
          cmp_c            = ($signed(dbus.rd1) <= 0);
        end
        6'h07: begin
          ibus_c[IDX_BGTZ] = 1'b1;
          ext_c            = 1'b1;
          branch_c         = 1'b1;
          cmp_c            = ($signed(dbus.rd1) > 0);
        end
        6'h01: begin
          if (dbus.instr[20:16] == 5'd0) begin
            ibus_c[IDX_BLTZ] = 1'b1;
            ext_c            = 1'b1;
            branch_c         = 1'b1;
            cmp_c            = ($signed(dbus.rd1) < 0);
          end else if (dbus.instr[20:16] == 5'd1) begin
            ibus_c[IDX_BGEZ] = 1'b1;
            ext_c            = 1'b1;
            branch_c         = 1'b1;
            cmp_c            = ($signed(dbus.rd1) >= 0);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Destination register select and immediate extension feeding the E register
  always_comb begin
    wra_c = 5'd0;
    case (reg_dst_c)
      2'b01:   wra_c = dbus.instr[20:16];
      2'b10:   wra_c = dbus.instr[15:11];
      2'b11:   wra_c = RA_ADDR;
      default: wra_c = 5'd0;
    endcase
    ext_val_c = ext_c ? {{16{dbus.instr[15]}}, dbus.instr[15:0]}
                      : {16'h0000, dbus.instr[15:0]};
  end

  // D->E control register; a stall loads a bubble instead of the decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_ibus_q <= '0;
      e_wra_q  <= '0;
      e_ext_q  <= '0;
    end else if (dbus.stall) begin
      e_ibus_q <= '0;
      e_wra_q  <= '0;
      e_ext_q  <= '0;
    end else begin
      e_ibus_q <= ibus_c;
      e_wra_q  <= wra_c;
      e_ext_q  <= ext_val_c;
    end
  end

  assign dbus.ibus        = ibus_c;
  assign dbus.ext_op      = ext_c;
  assign dbus.reg_dst     = reg_dst_c;
  assign dbus.is_branch   = branch_c;
  assign dbus.imm_jump    = imm_jump_c;
  assign dbus.reg_jump    = reg_jump_c;
  assign dbus.cmp_true    = cmp_c;
  assign dbus.branch_jump = cmp_c & branch_c;
  assign dbus.e_ibus      = e_ibus_q;
  assign dbus.e_wra       = e_wra_q;
  assign dbus.e_ext       = e_ext_q;

endmodule

// File: tb/tb_id_decode_cmp.sv
// Testbench for id_decode_cmp: directed instruction vectors with hand-computed
// expectations pushed into scoreboard queues; separate monitors check the
// combinational decode and the D->E register.
module tb_id_decode_cmp;

  typedef struct {
    logic [15:0] ibus;
    logic        ext_op;
    logic [1:0]  reg_dst;
    logic        is_branch;
    logic        imm_jump;
    logic        reg_jump;
    logic        cmp_true;
    logic        branch_jump;
  } comb_t;

  typedef struct {
    logic [15:0] e_ibus;
    logic [4:0]  e_wra;
    logic [31:0] e_ext;
  } reg_t;

  logic clk;
  logic reset;
  int   n_compared;
  int   n_failed;

  comb_t comb_q[$];
  reg_t  reg_q[$];

  id_decode_cmp_if dbus ();

  id_decode_cmp dut (
    .clk   (clk),
    .reset (reset),
    .dbus  (dbus.slave)
  );

  // Free-running clock, 10-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic comb_t mk_c(input logic [15:0] ib, input logic ext, input logic [1:0] rdst,
                                 input logic br, input logic ij, input logic rj,
                                 input logic cmp, input logic bj);
    comb_t c;
    c.ibus = ib; c.ext_op = ext; c.reg_dst = rdst; c.is_branch = br;
    c.imm_jump = ij; c.reg_jump = rj; c.cmp_true = cmp; c.branch_jump = bj;
    return c;
  endfunction

  function automatic reg_t mk_r(input logic [15:0] ib, input logic [4:0] wra, input logic [31:0] ext);
    reg_t r;
    r.e_ibus = ib; r.e_wra = wra; r.e_ext = ext;
    return r;
  endfunction

  // Drive one vector on the falling edge and queue its expected responses
  task automatic apply_stimulus(input logic [31:0] instr, input logic [31:0] rd1,
                                input logic [31:0] rd2, input logic stall,
                                input comb_t ce, input reg_t re);
    @(negedge clk);
    dbus.instr = instr;
    dbus.rd1   = rd1;
    dbus.rd2   = rd2;
    dbus.stall = stall;
    comb_q.push_back(ce);
    reg_q.push_back(re);
  endtask

  // Combinational monitor: samples mid-low-phase after each driven vector
  initial begin
    comb_t c;
    forever begin
      @(negedge clk);
      #3;
      if (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        check_output("ibus",        {16'h0, dbus.ibus},        {16'h0, c.ibus});
        check_output("ext_op",      {31'h0, dbus.ext_op},      {31'h0, c.ext_op});
        check_output("reg_dst",     {30'h0, dbus.reg_dst},     {30'h0, c.reg_dst});
        check_output("is_branch",   {31'h0, dbus.is_branch},   {31'h0, c.is_branch});
        check_output("imm_jump",    {31'h0, dbus.imm_jump},    {31'h0, c.imm_jump});
        check_output("reg_jump",    {31'h0, dbus.reg_jump},    {31'h0, c.reg_jump});
        check_output("cmp_true",    {31'h0, dbus.cmp_true},    {31'h0, c.cmp_true});
        check_output("branch_jump", {31'h0, dbus.branch_jump}, {31'h0, c.branch_jump});
      end
    end
  end

  // Register monitor: samples just after the rising edge that follows a vector
  initial begin
    reg_t r;
    forever begin
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
        r = reg_q.pop_front();
        check_output("e_ibus", {16'h0, dbus.e_ibus}, {16'h0, r.e_ibus});
        check_output("e_wra",  {27'h0, dbus.e_wra},  {27'h0, r.e_wra});
        check_output("e_ext",  dbus.e_ext,           r.e_ext);
      end
    end
  end

  // Watchdog so the bench always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Directed stimulus sequence
  initial begin
    n_compared = 0;
    n_failed   = 0;
    reset      = 1'b0;
    dbus.instr = 32'h0;
    dbus.rd1   = 32'h0;
    dbus.rd2   = 32'h0;
    dbus.stall = 1'b0;

    #2;
    check_output("reset_e_ibus", {16'h0, dbus.e_ibus}, 32'h0);
    check_output("reset_e_wra",  {27'h0, dbus.e_wra},  32'h0);
    check_output("reset_e_ext",  dbus.e_ext,           32'h0);
    @(negedge clk);
    reset = 1'b1;

    // addu $3,$1,$2
    apply_stimulus(32'h0022_1821, 32'h0, 32'h0, 1'b0,
                   mk_c(16'h0002, 0, 2'b10, 0, 0, 0, 0, 0), mk_r(16'h0002, 5'd3, 32'h0000_1821));
    // ori $5,$0,0x8000 (zero-extended)
    apply_stimulus(32'h3405_8000, 32'h0, 32'h0, 1'b0,
                   mk_c(16'h0008, 0, 2'b01, 0, 0, 0, 0, 0), mk_r(16'h0008, 5'd5, 32'h0000_8000));
    // beq equal operands
    apply_stimulus(32'h1022_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0,
                   mk_c(16'h0040, 1, 2'b00, 1, 0, 0, 1, 1), mk_r(16'h0040, 5'd0, 32'h0000_0004));
    // beq differing in LSB, negative offset
    apply_stimulus(32'h1022_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEE, 1'b0,
                   mk_c(16'h0040, 1, 2'b00, 1, 0, 0, 0, 0), mk_r(16'h0040, 5'd0, 32'hFFFF_FFFF));
    // jal
    apply_stimulus(32'h0C00_0010, 32'h0, 32'h0, 1'b0,
                   mk_c(16'h0100, 0, 2'b11, 0, 1, 0, 0, 0), mk_r(16'h0100, 5'd31, 32'h0000_0010));
    // jr $31
    apply_stimulus(32'h03E0_0008, 32'h0, 32'h0, 1'b0,
                   mk_c(16'h0200, 0, 2'b00, 0, 0, 1, 0, 0), mk_r(16'h0200, 5'd0, 32'h0000_0008));
    // lw $4,-4($1) stalled -> bubble
    apply_stimulus(32'h8C24_FFFC, 32'h0, 32'h0, 1'b1,
                   mk_c(16'h0010, 1, 2'b01, 0, 0, 0, 0, 0), mk_r(16'h0000, 5'd0, 32'h0000_0000));
    // lw $4,-4($1) released
    apply_stimulus(32'h8C24_FFFC, 32'h0, 32'h0, 1'b0,
                   mk_c(16'h0010, 1, 2'b01, 0, 0, 0, 0, 0), mk_r(16'h0010, 5'd4, 32'hFFFF_FFFC));
    // sw $4,8($1)
    apply_stimulus(32'hAC24_0008, 32'h0, 32'h0, 1'b0,
                   mk_c(16'h0020, 1, 2'b00, 0, 0, 0, 0, 0), mk_r(16'h0020, 5'd0, 32'h0000_0008));
    // lui $7,0x1234
    apply_stimulus(32'h3C07_1234, 32'h0, 32'h0, 1'b0,
                   mk_c(16'h0080, 0, 2'b01, 0, 0, 0, 0, 0), mk_r(16'h0080, 5'd7, 32'h0000_1234));
    // j
    apply_stimulus(32'h0800_0100, 32'h0, 32'h0, 1'b0,
                   mk_c(16'h0400, 0, 2'b00, 0, 1, 0, 0, 0), mk_r(16'h0400, 5'd0, 32'h0000_0100));
    // subu $6,$1,$2
    apply_stimulus(32'h0022_3023, 32'h0, 32'h0, 1'b0,
                   mk_c(16'h0004, 0, 2'b10, 0, 0, 0, 0, 0), mk_r(16'h0004, 5'd6, 32'h0000_3023));
    // nop
    apply_stimulus(32'h0000_0000, 32'h0, 32'h0, 1'b0,
                   mk_c(16'h0001, 0, 2'b00, 0, 0, 0, 0, 0), mk_r(16'h0001, 5'd0, 32'h0000_0000));
    // add (funct 20h) is unknown: no decode, immediate still zero-extended
    apply_stimulus(32'h0022_1820, 32'h1, 32'h1, 1'b0,
                   mk_c(16'h0000, 0, 2'b00, 0, 0, 0, 0, 0), mk_r(16'h0000, 5'd0, 32'h0000_1820));
`ifdef EXT_BRANCH_EN
    apply_stimulus(32'h1422_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEE, 1'b0,
                   mk_c(16'h0800, 1, 2'b00, 1, 0, 0, 1, 1), mk_r(16'h0800, 5'd0, 32'h0000_0004));
    apply_stimulus(32'h0421_0008, 32'h0, 32'h0, 1'b0,
                   mk_c(16'h8000, 1, 2'b00, 1, 0, 0, 1, 1), mk_r(16'h8000, 5'd0, 32'h0000_0008));
    apply_stimulus(32'h1820_0010, 32'h8000_0000, 32'h0, 1'b0,
                   mk_c(16'h1000, 1, 2'b00, 1, 0, 0, 1, 1), mk_r(16'h1000, 5'd0, 32'h0000_0010));
`else
    apply_stimulus(32'h1422_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEE, 1'b0,
                   mk_c(16'h0000, 0, 2'b00, 0, 0, 0, 0, 0), mk_r(16'h0000, 5'd0, 32'h0000_0004));
    apply_stimulus(32'h0421_0008, 32'h0, 32'h0, 1'b0,
                   mk_c(16'h0000, 0, 2'b00, 0, 0, 0, 0, 0), mk_r(16'h0000, 5'd0, 32'h0000_0008));
    apply_stimulus(32'h1820_0010, 32'h8000_0000, 32'h0, 1'b0,
                   mk_c(16'h0000, 0, 2'b00, 0, 0, 0, 0, 0), mk_r(16'h0000, 5'd0, 32'h0000_0010));
`endif

    // Load addu, then pull reset mid-cycle: E register must clear at once
    apply_stimulus(32'h0022_1821, 32'h0, 32'h0, 1'b0,
                   mk_c(16'h0002, 0, 2'b10, 0, 0, 0, 0, 0), mk_r(16'h0002, 5'd3, 32'h0000_1821));
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_output("async_rst_e_ibus", {16'h0, dbus.e_ibus}, 32'h0);
    check_output("async_rst_e_wra",  {27'h0, dbus.e_wra},  32'h0);
    check_output("async_rst_e_ext",  dbus.e_ext,           32'h0);

    // While held in reset the decode still works but E stays cleared
    apply_stimulus(32'h3405_8000, 32'h0, 32'h0, 1'b0,
                   mk_c(16'h0008, 0, 2'b01, 0, 0, 0, 0, 0), mk_r(16'h0000, 5'd0, 32'h0000_0000));
    @(posedge clk);
    #2;
    reset = 1'b1;

    // After release the next edge loads normally
    apply_stimulus(32'h0022_1821, 32'h0, 32'h0, 1'b0,
                   mk_c(16'h0002, 0, 2'b10, 0, 0, 0, 0, 0), mk_r(16'h0002, 5'd3, 32'h0000_1821));
    @(posedge clk);
    #3;

    check_output("comb_q_drained", comb_q.size(), 32'd0);
    check_output("reg_q_drained",  reg_q.size(),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
